// File: rtl/tl_cntr_w_left_timed_if.sv
// Sensor/lamp bundle between the traffic-light controller and its environment.
// The slave side is the controller; the master side drives sensors and watches the lamps.
interface tl_cntr_w_left_timed_if #(
  parameter int unsigned CNT_W = 4
);
  logic             Ta;
  logic             Tal;
  logic             Tb;
  logic             Tbl;
  logic [1:0]       La;
  logic [1:0]       Lb;
  logic [2:0]       state;
  logic [CNT_W-1:0] timer;

  modport master (
    output Ta, Tal, Tb, Tbl,
    input  La, Lb, state, timer
  );

  modport slave (
    input  Ta, Tal, Tb, Tbl,
    output La, Lb, state, timer
  );
endinterface

// File: rtl/tl_cntr_w_left_timed.sv
// Two-road traffic light controller with optional left-turn phases and
// min-green / max-green / fixed-yellow dwell timing per state.
module tl_cntr_w_left_timed #(
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned T_MIN_GRN = 4,
  parameter int unsigned T_MAX_GRN = 10,
  parameter int unsigned T_YEL     = 2,
  parameter int unsigned LEFT_EN   = 1
) (
  input logic                  clk,
  input logic                  reset,
  tl_cntr_w_left_timed_if.slave bus
);

  localparam logic [2:0] A_GRN  = 3'd0;
  localparam logic [2:0] A_YEL  = 3'd1;
  localparam logic [2:0] A_LFT  = 3'd2;
  localparam logic [2:0] A_LYEL = 3'd3;
  localparam logic [2:0] B_GRN  = 3'd4;
  localparam logic [2:0] B_YEL  = 3'd5;
  localparam logic [2:0] B_LFT  = 3'd6;
  localparam logic [2:0] B_LYEL = 3'd7;

  localparam logic [1:0] LAMP_GRN = 2'b00;
  localparam logic [1:0] LAMP_YEL = 2'b01;
  localparam logic [1:0] LAMP_RED = 2'b10;
  localparam logic [1:0] LAMP_LFT = 2'b11;

  // Timer values at which a phase is allowed / forced to end.
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(T_MIN_GRN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(T_MAX_GRN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(T_YEL - 1);
  localparam logic             LEFT_ON  = (LEFT_EN != 0);

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [CNT_W-1:0] timer_q;
  logic [CNT_W-1:0] timer_d;
  logic [1:0]       la_q;
  logic [1:0]       la_d;
  logic [1:0]       lb_q;
  logic [1:0]       lb_d;

  logic min_ok;
  logic max_hit;
  logic yel_hit;

  // Road A lamp for a given state; road A is red in every B state.
  function automatic logic [1:0] lamp_a(input logic [2:0] s);
    logic [1:0] l;
    l = LAMP_RED;
    case (s)
      A_GRN:         l = LAMP_GRN;
      A_YEL, A_LYEL: l = LAMP_YEL;
      A_LFT:         l = LAMP_LFT;
      default:       l = LAMP_RED;
    endcase
    return l;
  endfunction

  // Road B lamp, mirror of road A.
  function automatic logic [1:0] lamp_b(input logic [2:0] s);
    logic [1:0] l;
    l = LAMP_RED;
    case (s)
      B_GRN:         l = LAMP_GRN;
      B_YEL, B_LYEL: l = LAMP_YEL;
      B_LFT:         l = LAMP_LFT;
      default:       l = LAMP_RED;
    endcase
    return l;
  endfunction

  // Dwell qualifiers from the current-state timer.
  always_comb begin
    min_ok  = 1'b0;
    max_hit = 1'b0;
    yel_hit = 1'b0;
    min_ok  = (timer_q >= MIN_LAST);
    max_hit = (timer_q == MAX_LAST);
    yel_hit = (timer_q == YEL_LAST);
  end

  // Next state, next timer and next lamps; lamps are decoded from the next
  // state so the registered lamps change on the same edge as the state.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    la_d    = LAMP_GRN;
    lb_d    = LAMP_RED;

    case (state_q)
      A_GRN: begin
        if (min_ok && (!bus.Ta || max_hit)) state_d = A_YEL;
      end
      A_YEL: begin
        if (yel_hit) state_d = (LEFT_ON && bus.Tal) ? A_LFT : B_GRN;
      end
      A_LFT: begin
        if (!LEFT_ON)                             state_d = A_GRN;
        else if (min_ok && (!bus.Tal || max_hit)) state_d = A_LYEL;
      end
      A_LYEL: begin
        if (!LEFT_ON)     state_d = A_GRN;
        else if (yel_hit) state_d = B_GRN;
      end
      B_GRN: begin
        if (min_ok && (!bus.Tb || max_hit)) state_d = B_YEL;
      end
      B_YEL: begin
        if (yel_hit) state_d = (LEFT_ON && bus.Tbl) ? B_LFT : A_GRN;
      end
      B_LFT: begin
        if (!LEFT_ON)                             state_d = A_GRN;
        else if (min_ok && (!bus.Tbl || max_hit)) state_d = B_LYEL;
      end
      B_LYEL: begin
        if (!LEFT_ON)     state_d = A_GRN;
        else if (yel_hit) state_d = A_GRN;
      end
      default: state_d = A_GRN;
    endcase

    // Timer restarts on a state change and saturates otherwise.
    if (state_d != state_q)    timer_d = '0;
    else if (timer_q == '1)    timer_d = timer_q;
    else                       timer_d = timer_q + CNT_W'(1);

    la_d = lamp_a(state_d);
    lb_d = lamp_b(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= A_GRN;
      timer_q <= '0;
      la_q    <= LAMP_GRN;
      lb_q    <= LAMP_RED;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      la_q    <= la_d;
      lb_q    <= lb_d;
    end
  end

  assign bus.state = state_q;
  assign bus.timer = timer_q;
  assign bus.La    = la_q;
  assign bus.Lb    = lb_q;

endmodule

// File: tb/tb_tl_cntr_w_left_timed.sv
// Directed vector bench for the timed traffic-light controller, with a second
// instance built without left-turn phases.
module tb_tl_cntr_w_left_timed;

  localparam logic [1:0] G = 2'b00;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] R = 2'b10;
  localparam logic [1:0] L = 2'b11;

  typedef struct {
    logic       rst;
    logic       ta;
    logic       tal;
    logic       tb;
    logic       tbl;
    logic [2:0] st;
    logic [3:0] tm;
    logic [1:0] la;
    logic [1:0] lb;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic reset2;
  int   errors = 0;
  int   checks = 0;
  logic mon_en = 1'b0;
  vec_t vec_q[$];

  tl_cntr_w_left_timed_if #(.CNT_W(4)) bus_a ();
  tl_cntr_w_left_timed_if #(.CNT_W(4)) bus_b ();

  tl_cntr_w_left_timed #(.CNT_W(4), .T_MIN_GRN(4), .T_MAX_GRN(10), .T_YEL(2), .LEFT_EN(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  tl_cntr_w_left_timed #(.CNT_W(4), .T_MIN_GRN(4), .T_MAX_GRN(10), .T_YEL(2), .LEFT_EN(0)) dut_nl (
    .clk   (clk),
    .reset (reset2),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Queue n vectors with identical inputs and an incrementing expected timer.
  task automatic add(input int n, input logic rst, input logic ta, input logic tal,
                     input logic tb, input logic tbl, input logic [2:0] st, input int t0,
                     input logic [1:0] la, input logic [1:0] lb);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.rst = rst; v.ta = ta; v.tal = tal; v.tb = tb; v.tbl = tbl;
      v.st = st; v.tm = 4'(t0 + i); v.la = la; v.lb = lb;
      vec_q.push_back(v);
    end
  endtask

  // Road exclusivity on the left-enabled instance, every cycle after reset.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (bus_a.La != R && bus_a.Lb != R) begin
        errors++;
        $display("FAIL exclusivity: La=%0b Lb=%0b both non-red", bus_a.La, bus_a.Lb);
      end
    end
  end

  initial begin
    int idx;
    int pos;
    logic [2:0] exp_st;
    logic [3:0] exp_tm;

    reset = 1'b1; reset2 = 1'b1;
    bus_a.Ta = 1'b0; bus_a.Tal = 1'b0; bus_a.Tb = 1'b0; bus_a.Tbl = 1'b0;
    bus_b.Ta = 1'b0; bus_b.Tal = 1'b1; bus_b.Tb = 1'b0; bus_b.Tbl = 1'b1;

    //  n  rst ta tal tb tbl st t0 La Lb
    add(1, 1, 0, 0, 0, 0, 3'd0, 0, G, R);
    add(1, 1, 0, 0, 0, 0, 3'd0, 0, G, R);
    add(3, 0, 0, 0, 0, 0, 3'd0, 1, G, R);
    add(2, 0, 0, 0, 0, 0, 3'd1, 0, Y, R);
    add(4, 0, 0, 0, 0, 0, 3'd4, 0, R, G);
    add(2, 0, 0, 0, 0, 0, 3'd5, 0, R, Y);
    add(1, 0, 0, 0, 0, 0, 3'd0, 0, G, R);
    // Ta held: max green forces exit after timer 9
    add(9, 0, 1, 0, 0, 0, 3'd0, 1, G, R);
    add(1, 0, 1, 0, 0, 0, 3'd1, 0, Y, R);
    add(1, 0, 0, 0, 0, 0, 3'd1, 1, Y, R);
    // Tal present at the yellow exit: six-cycle left phase
    add(6, 0, 0, 1, 0, 0, 3'd2, 0, L, R);
    add(2, 0, 0, 0, 0, 0, 3'd3, 0, Y, R);
    add(4, 0, 0, 0, 0, 0, 3'd4, 0, R, G);
    add(2, 0, 0, 0, 0, 0, 3'd5, 0, R, Y);
    add(1, 0, 0, 0, 0, 0, 3'd0, 0, G, R);
    // Tal pulse mid-green only: left phase skipped
    add(1, 0, 0, 1, 0, 0, 3'd0, 1, G, R);
    add(2, 0, 0, 0, 0, 0, 3'd0, 2, G, R);
    add(2, 0, 0, 0, 0, 0, 3'd1, 0, Y, R);
    add(1, 0, 0, 0, 0, 0, 3'd4, 0, R, G);
    // Tb drops before min green: phase not shortened
    add(2, 0, 0, 0, 1, 0, 3'd4, 1, R, G);
    add(1, 0, 0, 0, 0, 0, 3'd4, 3, R, G);
    add(2, 0, 0, 0, 0, 0, 3'd5, 0, R, Y);
    add(1, 0, 0, 0, 0, 1, 3'd6, 0, R, L);
    add(3, 0, 0, 0, 0, 0, 3'd6, 1, R, L);
    add(2, 0, 0, 0, 0, 0, 3'd7, 0, R, Y);
    add(4, 0, 0, 0, 0, 0, 3'd0, 0, G, R);
    add(2, 0, 0, 0, 0, 0, 3'd1, 0, Y, R);
    add(4, 0, 0, 0, 0, 0, 3'd4, 0, R, G);
    add(2, 0, 0, 0, 0, 0, 3'd5, 0, R, Y);
    // Reset during B_YEL timer=1, held two edges
    add(1, 1, 0, 0, 0, 0, 3'd0, 0, G, R);
    add(1, 1, 0, 0, 0, 0, 3'd0, 0, G, R);
    add(1, 0, 0, 0, 0, 0, 3'd0, 1, G, R);

    idx = 0;
    foreach (vec_q[i]) begin
      reset     = vec_q[i].rst;
      bus_a.Ta  = vec_q[i].ta;
      bus_a.Tal = vec_q[i].tal;
      bus_a.Tb  = vec_q[i].tb;
      bus_a.Tbl = vec_q[i].tbl;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      check("state", idx, 32'(bus_a.state), 32'(vec_q[i].st));
      check("timer", idx, 32'(bus_a.timer), 32'(vec_q[i].tm));
      check("La",    idx, 32'(bus_a.La),    32'(vec_q[i].la));
      check("Lb",    idx, 32'(bus_a.Lb),    32'(vec_q[i].lb));
      idx++;
    end

    // Left-disabled instance: left demand always on, 4+2+4+2 cycle rotation.
    reset2 = 1'b1;
    @(posedge clk);
    #1;
    reset2 = 1'b0;
    check("nl_reset_state", 0, 32'(bus_b.state), 32'd0);
    check("nl_reset_timer", 0, 32'(bus_b.timer), 32'd0);
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk);
      #1;
      pos = k % 12;
      if (pos < 4)       begin exp_st = 3'd0; exp_tm = 4'(pos);      end
      else if (pos < 6)  begin exp_st = 3'd1; exp_tm = 4'(pos - 4);  end
      else if (pos < 10) begin exp_st = 3'd4; exp_tm = 4'(pos - 6);  end
      else               begin exp_st = 3'd5; exp_tm = 4'(pos - 10); end
      check("nl_state", k, 32'(bus_b.state), 32'(exp_st));
      check("nl_timer", k, 32'(bus_b.timer), 32'(exp_tm));
      checks++;
      if (bus_b.state[1] !== 1'b0) begin
        errors++;
        $display("FAIL nl_left_state at step %0d: got %0d expected one of 0,1,4,5", k, bus_b.state);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
